// File: rtl/uart_cfg_regfile_mc.sv
// ---------------------------------------------------------------------------
// uart_cfg_regfile_mc
//
// Multi-channel UART configuration register file. Each of N_CH channels owns
// a four-register bank at address ch*4+reg:
//   reg0 CTRL    RW  bit0 -> uart_enable[c], bits[3:1] -> uart_mode[3c+2:3c]
//   reg1 RATE    RW  shadow baud rate (low 16 bits, upper bits read 0)
//   reg2 STATUS  RO  bit0 live busy, bit1 sticky error, bit2 commit pending
//   reg3 SCRATCH RW
// A RATE write lands in the shadow; the shadow is copied to the active rate
// (uart_rate) only on a clock edge where that channel's UART is idle.
//
// Optional feature macro: UART_CFG_ERR_CLR_EN
//   defined   -> STATUS is writable, wr_data[1]=1 clears the sticky error
//   undefined -> STATUS writes are illegal and pulse wr_err
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data    host write port
//   rd_en_x/rd_addr_x        host read ports A and B (fully independent)
//   rd_data_x/rd_valid_x     read data / valid (latency set by READ_LATENCY)
//   uart_busy, uart_error    per-channel status from the UART cores
//   uart_enable/mode/rate    per-channel configuration to the UART cores
//   update_ok                one-cycle pulse per rate commit, per channel
//   wr_err                   one-cycle pulse after an illegal write
//
// Commit FSM (one instance per channel):
//   state      | meaning
//   ST_IDLE    | active rate matches the last committed shadow
//   ST_PENDING | shadow written, waiting for an edge with uart_busy[c]=0
// ---------------------------------------------------------------------------
module uart_cfg_regfile_mc #(
    parameter int DATA_WIDTH   = 16,
    parameter int N_CH         = 2,
    parameter int READ_LATENCY = 0,
    parameter int RATE_RESET   = 9600,
    localparam int AW          = $clog2(N_CH) + 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en_a,
    input  logic                    rd_en_b,
    input  logic [AW-1:0]           rd_addr_a,
    input  logic [AW-1:0]           rd_addr_b,
    output logic [DATA_WIDTH-1:0]   rd_data_a,
    output logic [DATA_WIDTH-1:0]   rd_data_b,
    output logic                    rd_valid_a,
    output logic                    rd_valid_b,
    input  logic [N_CH-1:0]         uart_busy,
    input  logic [N_CH-1:0]         uart_error,
    output logic [N_CH-1:0]         uart_enable,
    output logic [3*N_CH-1:0]       uart_mode,
    output logic [16*N_CH-1:0]      uart_rate,
    output logic [N_CH-1:0]         update_ok,
    output logic                    wr_err
);

    localparam int NREG = 4 * N_CH;
    localparam int CW   = AW - 2;
    localparam logic [15:0] RATE_RST = 16'(RATE_RESET);

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_RATE = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_SCR  = 2'd3;

`ifdef UART_CFG_ERR_CLR_EN
    localparam bit ERR_CLR_EN = 1'b1;
`else
    localparam bit ERR_CLR_EN = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_state_t;

    commit_state_t state_q [N_CH];
    commit_state_t state_d [N_CH];

    logic [DATA_WIDTH-1:0] ctrl_q   [N_CH];
    logic [DATA_WIDTH-1:0] scr_q    [N_CH];
    logic [15:0]           shadow_q [N_CH];
    logic [15:0]           active_q [N_CH];
    logic [N_CH-1:0]       err_q;
    logic [N_CH-1:0]       update_ok_q;
    logic                  wr_err_q;

    // ---------------- write decode ----------------
    logic            wr_in_range;
    logic [1:0]      wr_reg;
    logic            wr_illegal;
    logic [N_CH-1:0] ctrl_we, rate_we, scr_we, stat_we, err_clr, commit;

    assign wr_in_range = (32'(wr_addr) < 32'(NREG));
    assign wr_reg      = wr_addr[1:0];
    assign wr_illegal  = wr_en && (!wr_in_range || (wr_reg == REG_STAT && !ERR_CLR_EN));

    always_comb begin
        ctrl_we = '0;
        rate_we = '0;
        scr_we  = '0;
        stat_we = '0;
        err_clr = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (wr_en && wr_in_range && (wr_addr[AW-1:2] == CW'(c))) begin
                ctrl_we[c] = (wr_reg == REG_CTRL);
                rate_we[c] = (wr_reg == REG_RATE);
                scr_we[c]  = (wr_reg == REG_SCR);
                stat_we[c] = (wr_reg == REG_STAT);
            end
            err_clr[c] = ERR_CLR_EN && stat_we[c] && wr_data[1];
        end
    end

    // ---------------- commit FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) state_q[c] <= ST_IDLE;
        end else begin
            for (int c = 0; c < N_CH; c++) state_q[c] <= state_d[c];
        end
    end

    // A RATE write on the commit edge keeps the channel pending: the old
    // shadow commits now and the freshly written value commits next idle edge.
    always_comb begin
        commit = '0;
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                ST_IDLE: begin
                    if (rate_we[c]) state_d[c] = ST_PENDING;
                end
                ST_PENDING: begin
                    if (!uart_busy[c]) begin
                        commit[c]  = 1'b1;
                        state_d[c] = rate_we[c] ? ST_PENDING : ST_IDLE;
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    // ---------------- register storage ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                ctrl_q[c]   <= '0;
                scr_q[c]    <= '0;
                shadow_q[c] <= RATE_RST;
                active_q[c] <= RATE_RST;
            end
            err_q       <= '0;
            update_ok_q <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (ctrl_we[c]) ctrl_q[c]   <= wr_data;
                if (scr_we[c])  scr_q[c]    <= wr_data;
                if (rate_we[c]) shadow_q[c] <= wr_data[15:0];
                if (commit[c])  active_q[c] <= shadow_q[c];
                // a new error wins over a same-cycle clear
                err_q[c] <= uart_error[c] | (err_q[c] & ~err_clr[c]);
            end
            update_ok_q <= commit;
            wr_err_q    <= wr_illegal;
        end
    end

    // ---------------- read path ----------------
    logic [DATA_WIDTH-1:0] reg_view [NREG];
    logic [DATA_WIDTH-1:0] wr_view;
    logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;
    logic                  wr_rw;
    logic                  bypass_a, bypass_b;

    always_comb begin
        for (int i = 0; i < NREG; i++) reg_view[i] = '0;
        for (int c = 0; c < N_CH; c++) begin
            reg_view[4*c+0] = ctrl_q[c];
            reg_view[4*c+1] = DATA_WIDTH'(shadow_q[c]);
            reg_view[4*c+2] = DATA_WIDTH'({state_q[c] == ST_PENDING, err_q[c], uart_busy[c]});
            reg_view[4*c+3] = scr_q[c];
        end
    end

    // Same-cycle write to an in-range RW register is forwarded to the reader;
    // STATUS is never forwarded because its content is not the written word.
    assign wr_rw    = wr_en && wr_in_range && (wr_reg != REG_STAT);
    assign wr_view  = (wr_reg == REG_RATE) ? DATA_WIDTH'(wr_data[15:0]) : wr_data;
    assign bypass_a = wr_rw && (wr_addr == rd_addr_a);
    assign bypass_b = wr_rw && (wr_addr == rd_addr_b);

    always_comb begin
        rd_word_a = '0;
        rd_word_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (32'(rd_addr_a) == 32'(i)) rd_word_a = reg_view[i];
            if (32'(rd_addr_b) == 32'(i)) rd_word_b = reg_view[i];
        end
        if (bypass_a) rd_word_a = wr_view;
        if (bypass_b) rd_word_b = wr_view;
    end

    if (READ_LATENCY == 0) begin : g_rd_comb
        assign rd_data_a  = rd_word_a;
        assign rd_data_b  = rd_word_b;
        assign rd_valid_a = rd_en_a;
        assign rd_valid_b = rd_en_b;
    end else begin : g_rd_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_a  <= '0;
                rd_data_b  <= '0;
                rd_valid_a <= 1'b0;
                rd_valid_b <= 1'b0;
            end else begin
                rd_valid_a <= rd_en_a;
                rd_valid_b <= rd_en_b;
                if (rd_en_a) rd_data_a <= rd_word_a;
                if (rd_en_b) rd_data_b <= rd_word_b;
            end
        end
    end

    // ---------------- UART-facing outputs ----------------
    always_comb begin
        uart_enable = '0;
        uart_mode   = '0;
        uart_rate   = '0;
        for (int c = 0; c < N_CH; c++) begin
            uart_enable[c]        = ctrl_q[c][0];
            uart_mode[3*c +: 3]   = ctrl_q[c][3:1];
            uart_rate[16*c +: 16] = active_q[c];
        end
    end

    assign update_ok = update_ok_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_uart_cfg_regfile_mc.sv
// ---------------------------------------------------------------------------
// tb_uart_cfg_regfile_mc
//
// Directed bench for uart_cfg_regfile_mc with default parameters
// (DATA_WIDTH=16, N_CH=2, READ_LATENCY=0, RATE_RESET=9600).
// Stimulus pushes expected read data, rate commits and wr_err pulses into
// queues; a negedge monitor pops and compares whenever the DUT presents
// rd_valid_x, update_ok[c] or wr_err.
// ---------------------------------------------------------------------------
module tb_uart_cfg_regfile_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en_a, rd_en_b;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic [1:0]  uart_busy, uart_error;
    logic [1:0]  uart_enable;
    logic [5:0]  uart_mode;
    logic [31:0] uart_rate;
    logic [1:0]  update_ok;
    logic        wr_err;

    uart_cfg_regfile_mc dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en_a    (rd_en_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .rd_valid_a (rd_valid_a),
        .rd_valid_b (rd_valid_b),
        .uart_busy  (uart_busy),
        .uart_error (uart_error),
        .uart_enable(uart_enable),
        .uart_mode  (uart_mode),
        .uart_rate  (uart_rate),
        .update_ok  (update_ok),
        .wr_err     (wr_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] qa_data [$];
    string       qa_name [$];
    logic [15:0] qb_data [$];
    string       qb_name [$];
    logic [19:0] q_commit [$];   // {channel[3:0], rate[15:0]}
    int          exp_err = 0;

    localparam logic [15:0] R9600 = 16'h2580;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT output with nothing expected", name);
    endtask

    // ---------------- monitor ----------------
    logic [15:0] m_d;
    string       m_n;
    logic [19:0] m_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid_a) begin
                if (qa_data.size() == 0) unexpected("rd_a_unexpected");
                else begin
                    m_d = qa_data.pop_front();
                    m_n = qa_name.pop_front();
                    check(m_n, rd_data_a, m_d);
                end
            end
            if (rd_valid_b) begin
                if (qb_data.size() == 0) unexpected("rd_b_unexpected");
                else begin
                    m_d = qb_data.pop_front();
                    m_n = qb_name.pop_front();
                    check(m_n, rd_data_b, m_d);
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (update_ok[c]) begin
                    if (q_commit.size() == 0) unexpected("update_ok_unexpected");
                    else begin
                        m_e = q_commit.pop_front();
                        check("commit_channel", c, m_e[19:16]);
                        check("commit_rate", uart_rate[16*c +: 16], m_e[15:0]);
                    end
                end
            end
            if (wr_err) begin
                if (exp_err == 0) unexpected("wr_err_unexpected");
                else begin
                    exp_err--;
                    n_tests++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        wr_en      = 1'b0;
        rd_en_a    = 1'b0;
        rd_en_b    = 1'b0;
        uart_error = 2'b00;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
    endtask

    task automatic exp_a(input string name, input logic [3:0] addr, input logic [15:0] data);
        rd_en_a   = 1'b1;
        rd_addr_a = addr;
        qa_data.push_back(data);
        qa_name.push_back(name);
    endtask

    task automatic exp_b(input string name, input logic [3:0] addr, input logic [15:0] data);
        rd_en_b   = 1'b1;
        rd_addr_b = addr;
        qb_data.push_back(data);
        qb_name.push_back(name);
    endtask

    task automatic exp_commit(input logic [3:0] ch, input logic [15:0] rate);
        q_commit.push_back({ch, rate});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_en_a    = 1'b0;
        rd_en_b    = 1'b0;
        rd_addr_a  = '0;
        rd_addr_b  = '0;
        uart_busy  = 2'b00;
        uart_error = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset values
        check("rst_uart_rate", uart_rate, {R9600, R9600});
        check("rst_update_ok", update_ok, 2'b00);
        check("rst_wr_err", wr_err, 1'b0);
        check("rst_uart_enable", uart_enable, 2'b00);
        check("rst_uart_mode", uart_mode, 6'b0);
        for (int i = 0; i < 8; i++) begin
            exp_a("rst_read_a", 4'(i), (i % 4 == 1) ? R9600 : 16'h0000);
            exp_b("rst_read_b", 4'(7 - i), ((7 - i) % 4 == 1) ? R9600 : 16'h0000);
            cyc();
        end

        // RATE write held off by busy, then committed once busy drops
        uart_busy = 2'b01;
        wr(4'd1, 16'h4B00);
        cyc();
        for (int k = 0; k < 5; k++) begin
            check("busy_hold_rate0", uart_rate[15:0], R9600);
            check("busy_hold_no_update", update_ok, 2'b00);
            if (k == 0) begin
                exp_a("status0_busy_pending", 4'd2, 16'h0005);
                exp_b("rate0_shadow", 4'd1, 16'h4B00);
            end
            cyc();
        end
        exp_commit(4'd0, 16'h4B00);
        uart_busy = 2'b00;
        cyc();
        check("ch1_rate_unaffected", uart_rate[31:16], R9600);
        cyc();
        check("single_update_pulse", update_ok, 2'b00);
        check("rate0_after_commit", uart_rate[15:0], 16'h4B00);
        exp_a("status0_idle", 4'd2, 16'h0000);
        cyc();

        // write bypass on both ports, CTRL drives enable/mode
        wr(4'd7, 16'hA5A5);
        exp_a("bypass_scr1_a", 4'd7, 16'hA5A5);
        exp_b("bypass_scr1_b", 4'd7, 16'hA5A5);
        cyc();
        wr(4'd4, 16'h000B);
        exp_a("bypass_ctrl1", 4'd4, 16'h000B);
        cyc();
        check("ctrl1_enable", uart_enable, 2'b10);
        check("ctrl1_mode", uart_mode, 6'b101_000);
        exp_a("scr1_readback", 4'd7, 16'hA5A5);
        exp_b("ctrl1_readback", 4'd4, 16'h000B);
        cyc();

        // out-of-bounds read and write
        wr(4'd8, 16'h1234);
        exp_a("oob_read", 4'd8, 16'h0000);
        exp_err++;
        cyc();
        cyc();
        exp_a("oob_ctrl0_untouched", 4'd0, 16'h0000);
        exp_b("oob_scr1_untouched", 4'd7, 16'hA5A5);
        cyc();
        exp_a("oob_scr0_untouched", 4'd3, 16'h0000);
        check("oob_mode_untouched", uart_mode, 6'b101_000);
        check("oob_enable_untouched", uart_enable, 2'b10);
        cyc();

        // RATE write on the commit edge of a prior write (115200 -> low 16 bits 0xC200)
        wr(4'd5, 16'h9600);
        exp_commit(4'd1, 16'h9600);
        cyc();
        wr(4'd5, 16'hC200);
        exp_a("status1_pending", 4'd6, 16'h0004);
        exp_commit(4'd1, 16'hC200);
        cyc();
        check("first_commit_38400", uart_rate[31:16], 16'h9600);
        cyc();
        check("second_commit_115200", uart_rate[31:16], 16'hC200);
        exp_a("status1_after_two", 4'd6, 16'h0000);
        cyc();

        // repeated writes while pending: only the last one commits
        uart_busy = 2'b10;
        wr(4'd5, 16'h1111);
        cyc();
        wr(4'd5, 16'h2222);
        cyc();
        exp_a("rate1_last_shadow", 4'd5, 16'h2222);
        check("rate1_held", uart_rate[31:16], 16'hC200);
        cyc();
        exp_commit(4'd1, 16'h2222);
        uart_busy = 2'b00;
        cyc();
        check("rate1_last_commit", uart_rate[31:16], 16'h2222);
        cyc();

        // sticky error and STATUS write
        uart_error = 2'b10;
        cyc();
        exp_a("status1_err", 4'd6, 16'h0002);
        exp_b("status0_no_err", 4'd2, 16'h0000);
        cyc();
        repeat (3) cyc();
        exp_a("status1_err_sticky", 4'd6, 16'h0002);
        cyc();
        wr(4'd6, 16'h0002);
`ifndef UART_CFG_ERR_CLR_EN
        exp_err++;
`endif
        cyc();
        cyc();
`ifdef UART_CFG_ERR_CLR_EN
        exp_a("status1_after_w1c", 4'd6, 16'h0000);
`else
        exp_a("status1_after_ro_write", 4'd6, 16'h0002);
`endif
        cyc();
        uart_error = 2'b10;
        wr(4'd6, 16'h0002);
`ifndef UART_CFG_ERR_CLR_EN
        exp_err++;
`endif
        cyc();
        cyc();
        exp_a("status1_set_beats_clear", 4'd6, 16'h0002);
        cyc();

        // reset while a commit is pending discards the shadow
        uart_busy = 2'b01;
        wr(4'd1, 16'h7777);
        cyc();
        check("pre_reset_rate0", uart_rate[15:0], 16'h4B00);
        rst = 1'b1;
        #2;
        check("async_reset_rate0", uart_rate[15:0], R9600);
        check("async_reset_enable", uart_enable, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_a("post_reset_rate0", 4'd1, R9600);
        exp_b("post_reset_status0", 4'd2, 16'h0001);
        cyc();
        exp_a("post_reset_scr1", 4'd7, 16'h0000);
        exp_b("post_reset_status1", 4'd6, 16'h0000);
        cyc();
        uart_busy = 2'b00;
        repeat (3) cyc();
        check("post_reset_rate_kept", uart_rate, {R9600, R9600});

        repeat (2) cyc();
        check("sb_a_drained", qa_data.size(), 0);
        check("sb_b_drained", qb_data.size(), 0);
        check("commits_drained", q_commit.size(), 0);
        check("wr_err_drained", exp_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
